// File: rtl/alu_result_drain_if.sv
// Result stream from alu_result_drain to its consumer (host or UART bridge).
// A word moves on each rising clk edge where out_valid && out_ready; once raised, out_valid and out_data hold until that edge.
interface alu_result_drain_if #(
  parameter int DW = 9
) ();
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/alu_result_drain.sv
// Drains count words from the ALU result memory starting at base_addr onto a valid/ready stream, pulsing done at the end.
// Optional running checksum of streamed words is enabled by defining ALU_DRAIN_CHECKSUM_EN.
module alu_result_drain #(
  parameter int AW = 4,
  parameter int DW = 9,
  parameter int CW = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           count,
  output logic [AW-1:0]         rd_addr,
  input  logic [DW-1:0]         rd_data,
  alu_result_drain_if.master    out_if,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         checksum,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          start_acc;
  logic          hs;

  assign start_acc = (state_q == IDLE) && start;
  assign hs        = (state_q == SEND) && out_if.out_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    rd_addr_d  = rd_addr_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d     = base_addr;
          rem_d     = count;
          // Address goes out one edge early so the synchronous read lands in CAPTURE.
          rd_addr_d = base_addr;
          state_d   = (count != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        rd_addr_d = ptr_q;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        out_data_d = rd_data;
        ptr_d      = ptr_q + 1'b1;
        rem_d      = rem_q - 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (hs) begin
          if (rem_q != '0) begin
            rd_addr_d = ptr_q;
            state_d   = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      rd_addr_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      rd_addr_q  <= rd_addr_d;
      out_data_q <= out_data_d;
    end
  end

`ifdef ALU_DRAIN_CHECKSUM_EN
  logic [CW-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (start_acc) begin
      cksum_d = '0;
    end else if (hs) begin
      cksum_d = cksum_q + {{(CW-DW){1'b0}}, out_data_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign checksum = cksum_q;
`else
  logic unused_cksum;
  assign unused_cksum = start_acc;
  assign checksum     = '0;
`endif

  assign rd_addr          = rd_addr_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = (state_q == SEND);
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign dbg_state        = state_q;

endmodule
